// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multi-cycle sequencer: op encodings,
// FSM states, shared-ALU opcodes and small op-classification helpers.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_AND   = 2'd1;
    localparam logic [1:0] ALU_XOR   = 2'd2;
    localparam logic [1:0] ALU_OR    = 2'd3;

    localparam logic [1:0] ALU2_SLL  = 2'd0;
    localparam logic [1:0] ALU2_SLT  = 2'd1;
    localparam logic [1:0] ALU2_SR   = 2'd2;
    localparam logic [1:0] ALU2_PASS = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREP_A = 3'd1,
        ST_PREP_B = 3'd2,
        ST_ITER   = 3'd3,
        ST_FIX_LO = 3'd4,
        ST_FIX_HI = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_mulh(input logic [2:0] op);
        return !op[2] && (op != OP_MUL);
    endfunction

    function automatic logic state_owns_alu(input state_e st);
        return (st == ST_PREP_A) || (st == ST_PREP_B) || (st == ST_ITER) ||
               (st == ST_FIX_LO) || (st == ST_FIX_HI);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply / restoring divide: ALU operand shaping
// and next {hi, lo} (or {rem, quo}) from the two ALU lane results.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] alu_d,
    input  logic            alu_flag,
    output logic [XLEN-1:0] iter_a,
    output logic [XLEN-1:0] iter_b,
    output logic            iter_alt,
    output logic [XLEN-1:0] iter_a2,
    output logic [XLEN-1:0] iter_b2,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN-1:0] div_r_s;
    logic [XLEN-1:0] addend_s;
    logic            take_s;

    assign div_r_s  = {hi[XLEN-2:0], lo[XLEN-1]};
    assign addend_s = lo[0] ? b : 32'd0;

    // Lane-2 operands kept apart from lane 1: in multiply they depend on alu_d.
    assign iter_a2 = is_div ? div_r_s : alu_d;
    assign iter_b2 = is_div ? b : addend_s;

    // Lane-1 operands: r - divisor for divide, hi + addend for multiply.
    always_comb begin
        iter_a   = hi;
        iter_b   = addend_s;
        iter_alt = 1'b0;
        if (is_div) begin
            iter_a   = div_r_s;
            iter_b   = b;
            iter_alt = 1'b1;
        end else begin
            iter_a   = hi;
            iter_b   = addend_s;
            iter_alt = 1'b0;
        end
    end

    // Next accumulator; hi[31] set means the 33-bit partial remainder exceeds any divisor.
    always_comb begin
        take_s = 1'b0;
        hi_nxt = hi;
        lo_nxt = lo;
        if (is_div) begin
            take_s = hi[XLEN-1] | ~alu_flag;
            hi_nxt = take_s ? alu_d : div_r_s;
            lo_nxt = {lo[XLEN-2:0], take_s};
        end else begin
            take_s = 1'b0;
            hi_nxt = {alu_flag, alu_d[XLEN-1:1]};
            lo_nxt = {alu_d[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer driving the shared two-lane execute ALU:
// magnitude prep, 32 iterations, sign fix-up of lo then hi, then a held response.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    input  logic        kill,
    output logic        alu_own,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_op,
    output logic        alu_alt,
    output logic [31:0] alu_a2,
    output logic [31:0] alu_b2,
    output logic [1:0]  alu2_op,
    output logic        alu2_alt,
    input  logic [31:0] alu_d,
    input  logic [31:0] alu_d2
);

    state_e      state_r;
    state_e      state_seq_s;
    state_e      state_nxt_s;

    logic [2:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] orig_a_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [4:0]  cnt_r;
    logic        neg_a_r;
    logic        neg_b_r;
    logic        lo_zero_r;

    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_data_r;
    logic        alu_own_r;

    logic [31:0] iter_a_s;
    logic [31:0] iter_b_s;
    logic        iter_alt_s;
    logic [31:0] iter_a2_s;
    logic [31:0] iter_b2_s;
    logic [31:0] hi_nxt_s;
    logic [31:0] lo_nxt_s;
    logic [31:0] fix_src_s;
    logic        neg_res_s;
    logic [31:0] result_s;
    logic        unused_alu_d2_s;

    assign unused_alu_d2_s = ^alu_d2[31:1];

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign alu_own   = alu_own_r;

    // Remainder ops fix up the remainder (hi slot) and leave the result in lo.
    assign fix_src_s = op_is_rem(op_r) ? hi_r : lo_r;
    assign neg_res_s = op_is_rem(op_r) ? neg_a_r : (neg_a_r ^ neg_b_r);

    muldiv_step u_step (
        .is_div   (op_is_div(op_r)),
        .hi       (hi_r),
        .lo       (lo_r),
        .b        (b_r),
        .alu_d    (alu_d),
        .alu_flag (alu_d2[0]),
        .iter_a   (iter_a_s),
        .iter_b   (iter_b_s),
        .iter_alt (iter_alt_s),
        .iter_a2  (iter_a2_s),
        .iter_b2  (iter_b2_s),
        .hi_nxt   (hi_nxt_s),
        .lo_nxt   (lo_nxt_s)
    );

    // Sequencing without abort; kill is layered on afterwards.
    always_comb begin
        state_seq_s = state_r;
        case (state_r)
            ST_IDLE:   state_seq_s = req_valid ? ST_PREP_A : ST_IDLE;
            ST_PREP_A: state_seq_s = ST_PREP_B;
            ST_PREP_B: state_seq_s = (op_is_div(op_r) && (b_r == 32'd0)) ? ST_DONE : ST_ITER;
            ST_ITER:   state_seq_s = (cnt_r == 5'd31) ? ST_FIX_LO : ST_ITER;
            ST_FIX_LO: state_seq_s = ST_FIX_HI;
            ST_FIX_HI: state_seq_s = ST_DONE;
            ST_DONE:   state_seq_s = rsp_ready ? ST_IDLE : ST_DONE;
            default:   state_seq_s = ST_IDLE;
        endcase
    end

    assign state_nxt_s = (kill && (state_r != ST_IDLE)) ? ST_IDLE : state_seq_s;

    // Value captured into rsp_data on entry to DONE.
    always_comb begin
        result_s = lo_r;
        case (state_r)
            ST_PREP_B: result_s = op_is_rem(op_r) ? orig_a_r : 32'hFFFF_FFFF;
            ST_FIX_HI: result_s = op_is_mulh(op_r) ? alu_d : lo_r;
            default:   result_s = lo_r;
        endcase
    end

    // Lane 1: always ADD; subtract via alu_alt. Zero outside owned states.
    always_comb begin
        alu_a   = 32'd0;
        alu_b   = 32'd0;
        alu_op  = ALU_ADD;
        alu_alt = 1'b0;
        case (state_r)
            ST_PREP_A: begin
                alu_b   = a_r;
                alu_alt = 1'b1;
            end
            ST_PREP_B: begin
                alu_b   = b_r;
                alu_alt = 1'b1;
            end
            ST_ITER: begin
                alu_a   = iter_a_s;
                alu_b   = iter_b_s;
                alu_alt = iter_alt_s;
            end
            ST_FIX_LO: begin
                alu_a = neg_res_s ? ~fix_src_s : fix_src_s;
                alu_b = neg_res_s ? 32'd1 : 32'd0;
            end
            ST_FIX_HI: begin
                alu_a = neg_res_s ? ~hi_r : hi_r;
                alu_b = neg_res_s ? {31'd0, lo_zero_r} : 32'd0;
            end
            default: begin
                alu_a   = 32'd0;
                alu_b   = 32'd0;
                alu_alt = 1'b0;
            end
        endcase
    end

    // Lane 2: unsigned SLTU while owned; operands only meaningful during ITER.
    always_comb begin
        alu_a2   = 32'd0;
        alu_b2   = 32'd0;
        alu2_op  = ALU2_SLL;
        alu2_alt = 1'b0;
        if (state_owns_alu(state_r)) begin
            alu2_op = ALU2_SLT;
            if (state_r == ST_ITER) begin
                alu_a2 = iter_a2_s;
                alu_b2 = iter_b2_s;
            end else begin
                alu_a2 = 32'd0;
                alu_b2 = 32'd0;
            end
        end else begin
            alu2_op = ALU2_SLL;
        end
    end

    // State register and registered handshake/ownership outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'd0;
            alu_own_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_DONE);
            alu_own_r   <= state_owns_alu(state_nxt_s);
            if ((state_nxt_s == ST_DONE) && (state_r != ST_DONE)) begin
                rsp_data_r <= result_s;
            end
        end
    end

    // Operand, accumulator and sign bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= 3'd0;
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            orig_a_r  <= 32'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            cnt_r     <= 5'd0;
            neg_a_r   <= 1'b0;
            neg_b_r   <= 1'b0;
            lo_zero_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_r     <= req_op;
                        a_r      <= req_rs1;
                        b_r      <= req_rs2;
                        orig_a_r <= req_rs1;
                        neg_a_r  <= 1'b0;
                        neg_b_r  <= 1'b0;
                        cnt_r    <= 5'd0;
                    end
                end
                ST_PREP_A: begin
                    if (op_signed_a(op_r) && a_r[31]) begin
                        a_r     <= alu_d;
                        neg_a_r <= 1'b1;
                    end
                end
                ST_PREP_B: begin
                    if (op_signed_b(op_r) && b_r[31]) begin
                        b_r     <= alu_d;
                        neg_b_r <= 1'b1;
                    end
                    hi_r  <= 32'd0;
                    lo_r  <= a_r;
                    cnt_r <= 5'd0;
                end
                ST_ITER: begin
                    hi_r  <= hi_nxt_s;
                    lo_r  <= lo_nxt_s;
                    cnt_r <= cnt_r + 5'd1;
                end
                ST_FIX_LO: begin
                    lo_r      <= alu_d;
                    lo_zero_r <= (fix_src_s == 32'd0);
                end
                ST_FIX_HI: begin
                    hi_r <= alu_d;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural model of the shared two-lane ALU.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        kill;
    logic        alu_own;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_op;
    logic        alu_alt;
    logic [31:0] alu_a2;
    logic [31:0] alu_b2;
    logic [1:0]  alu2_op;
    logic        alu2_alt;
    logic [31:0] alu_d;
    logic [31:0] alu_d2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    muldiv_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .kill      (kill),
        .alu_own   (alu_own),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_alt   (alu_alt),
        .alu_a2    (alu_a2),
        .alu_b2    (alu_b2),
        .alu2_op   (alu2_op),
        .alu2_alt  (alu2_alt),
        .alu_d     (alu_d),
        .alu_d2    (alu_d2)
    );

    // Lane-1 ALU model.
    always_comb begin
        case (alu_op)
            2'd0:    alu_d = alu_alt ? (alu_a - alu_b) : (alu_a + alu_b);
            2'd1:    alu_d = alu_a & alu_b;
            2'd2:    alu_d = alu_a ^ alu_b;
            default: alu_d = alu_a | alu_b;
        endcase
    end

    // Lane-2 ALU model.
    always_comb begin
        case (alu2_op)
            2'd0:    alu_d2 = alu_a2 << alu_b2[4:0];
            2'd1:    alu_d2 = alu2_alt ? {31'd0, ($signed(alu_a2) < $signed(alu_b2))}
                                       : {31'd0, (alu_a2 < alu_b2)};
            2'd2:    alu_d2 = alu2_alt ? 32'($signed(alu_a2) >>> alu_b2[4:0])
                                       : (alu_a2 >> alu_b2[4:0]);
            default: alu_d2 = alu_a2;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, " alu_own"},   {31'd0, alu_own},   32'd0);
        check({tag, " alu_a|b"},   alu_a | alu_b | alu_a2 | alu_b2, 32'd0);
        check({tag, " alu ops"},   {28'd0, alu_op, alu2_op}, 32'd0);
    endtask

    // Issue one request, wait for the response, optionally stall, then retire it.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_cyc,
                          input int hold);
        int n;
        logic [31:0] first;
        @(negedge clk);
        check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, " own@1"}, {31'd0, alu_own}, 32'd1);
        n = 1;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " cycle"}, 32'(n), 32'(exp_cyc));
        check({tag, " data"}, rsp_data, exp);
        first = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold data"}, rsp_data, first);
            check({tag, " hold valid/ready/own"}, {29'd0, rsp_valid, req_ready, alu_own}, 32'd4);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " retired"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_rs1   = 32'd0;
        req_rs2   = 32'd0;
        rsp_ready = 1'b0;
        kill      = 1'b0;
        #12;
        check_idle_outputs("reset");
        check("reset rsp_data", rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("MULHU ffff*ffff", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 37, 0);
        run_op("MUL ffff*ffff",   OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 37, 0);
        run_op("MULH -7*3",       OP_MULH,   32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 37, 0);
        run_op("MULHSU -1*ffff",  OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 37, 0);
        run_op("MUL -7*3",        OP_MUL,    32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFEB, 37, 0);
        run_op("MULH min*min",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 37, 0);
        run_op("DIV -7/2",        OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 37, 0);
        run_op("REM -7/2",        OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 37, 0);
        run_op("DIV ovf",         OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 37, 0);
        run_op("REM ovf",         OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 37, 0);
        run_op("DIVU 5/0",        OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 3, 0);
        run_op("REMU 5/0",        OP_REMU,   32'd5,         32'd0,         32'd5,         3, 0);
        run_op("DIV -5/0",        OP_DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 3, 0);
        run_op("REM -5/0",        OP_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 3, 0);
        run_op("DIVU 100/7 bp",   OP_DIVU,   32'd100,       32'd7,         32'd14,        37, 5);
        run_op("REMU 100/7",      OP_REMU,   32'd100,       32'd7,         32'd2,         37, 0);
        check_idle_outputs("idle after ops");

        // Abort during the tenth iteration cycle (cycle 12 after accept).
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_MUL;
        req_rs1   = 32'd1234;
        req_rs2   = 32'd5678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (11) @(negedge clk);
        check("kill pre own", {31'd0, alu_own}, 32'd1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check_idle_outputs("after kill");
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("kill no response", 32'(seen), 32'd0);
        run_op("MUL after kill",  OP_MUL,    32'd1234,      32'd5678,      32'd7006652,   37, 0);

        // Asynchronous reset in the middle of ITER.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_rs1   = 32'd1000;
        req_rs2   = 32'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async reset");
        check("async reset rsp_data", rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("DIVU after reset", OP_DIVU,  32'd1000,      32'd3,         32'd333,       37, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
